xor_frame_buffer: RTL and testbench
===================================

Name: xor_frame_buffer

Overview:
- Parametrised frame-capture buffer for the FFT data path; successor to the fixed 8-bit XOR/counter test block.
- Accepts WIDTH-bit samples on a valid/ready input and XORs each with MASK.
- Stores DEPTH samples as one frame, then drains the frame in order on a valid/ready output.
- 2-bit FSM (IDLE/ACTIVE/DONE/ERROR) with inter-sample timeout, flush and a wrapping frame counter; sits between sample source and FFT input staging.

Parameters:
- WIDTH, 8, sample width in bits (>=1).
- DEPTH, 4, samples per frame (>=2).
- MASK, 8'hAA, XOR mask applied on capture; zero-extended or truncated to WIDTH.
- TIMEOUT, 16, max idle cycles allowed in ACTIVE between accepted samples (>=2).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous abort; returns to IDLE.
- in_valid_i  in  1  input sample valid.
- in_ready_o  out  1  input ready.
- in_data_i  in  WIDTH  input sample.
- out_valid_o  out  1  output sample valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  WIDTH  output sample (masked).
- state_o  out  2  FSM state: 00 IDLE, 01 ACTIVE, 10 DONE, 11 ERROR.
- count_o  out  $clog2(DEPTH+1)  samples currently held.
- frames_o  out  8  completed-frame counter, wraps 8'hFF->8'h00.
- error_o  out  1  high while in ERROR.

Behaviour:
- Reset, asynchronous on reset_n_i low:
  - state=IDLE; write/read indices, count_o, frames_o and timeout counter = 0.
  - in_ready_o=1, out_valid_o=0, error_o=0, out_data_o=0.
  - Array contents are don't-care.
- Accept and drain rules:
  - Input accept = in_valid_i & in_ready_o at the rising edge.
  - Output transfer = out_valid_o & out_ready_i at the rising edge.
- in_ready_o = 1 in IDLE/ACTIVE and 0 in DONE/ERROR. This is a decode of the registered state, with no combinational path from in_valid_i.
- out_valid_o = 1 only in DONE.
- out_data_o = mem[rd_idx] in DONE, 0 otherwise.
- Capture:
  - mem[wr_idx] <= in_data_i ^ MASK; wr_idx and count_o increment.
  - A sample accepted at edge n is readable from edge n+1.
- IDLE:
  - On accept, go to ACTIVE (count=1).
  - If DEPTH==… (n/a, DEPTH>=2).
- ACTIVE:
  - On the accept that makes count==DEPTH, go to DONE on that same edge. out_valid_o is high the following cycle, so minimum fill-to-first-output latency is 1 cycle.
- Timeout:
  - The counter clears on every accept and increments on every ACTIVE cycle without an accept.
  - When it reaches TIMEOUT-1 on a cycle with no accept, go to ERROR.
  - An accept on that same cycle wins: no error, counter cleared.
- DONE:
  - Each output transfer increments rd_idx and decrements count_o.
  - On the transfer of sample DEPTH-1, go to IDLE, clear the indices, and increment frames_o (modulo 256).
  - Backpressure (out_ready_i=0) holds out_data_o and out_valid_o stable indefinitely; there is no timeout in DONE.
- ERROR:
  - error_o=1, no accepts, no output.
  - Held until flush_i. Input valid is ignored.
- flush_i (any state):
  - Next state IDLE; indices, count and timeout counter cleared.
  - frames_o is unchanged; error_o is cleared.
  - flush_i overrides any accept, transfer or timeout on the same edge, and no sample is captured.
- Wrap-around:
  - Indices run 0..DEPTH-1 and reset per frame; no partial-frame reuse.
  - frames_o rolls 255->0 silently.
- Reset mid-frame: all state is discarded immediately (asynchronous); the partial frame is lost.
- All widths are unsigned; the XOR is bitwise at WIDTH bits.

Test Plan:
1. Reset, then in_valid_i=1 with samples 8'h00,8'h01,8'h02,8'h03, out_ready_i=1 -> state 01 after the 1st, 10 after the 4th; out_data_o sequence AA,AB,A8,A9; then state 00, frames_o=1.
2. Fill a frame, hold out_ready_i=0 for 10 cycles -> out_valid_o=1, out_data_o=AA stable, count_o=4; then release -> 4 transfers, count_o 4->0.
3. Accept one sample, then idle 15 cycles (TIMEOUT=16) -> state 11 and error_o=1 on the 15th idle edge; in_valid_i ignored; flush_i pulse -> state 00, count_o=0, error_o=0.
4. Accept on the exact timeout cycle (idle 14, accept on cycle 15) -> stays ACTIVE, no error, count_o=2.
5. Assert flush_i simultaneously with an accept in ACTIVE at count=3 -> state 00, count_o=0, no sample stored, frames_o unchanged.
6. Run 257 complete frames -> frames_o=8'h01. Then deassert reset_n_i mid-frame between clock edges -> outputs return to reset values immediately.

Source files
------------

// File: rtl/xor_frame_buffer_if.sv
// Sample-in / frame-out stream bundle for xor_frame_buffer.
// The master is the source/sink side; the buffer itself uses the slave modport.
interface xor_frame_buffer_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/xor_frame_buffer.sv
// Captures DEPTH masked samples as one frame, then drains it in order.
// Watches for inter-sample timeouts and supports a synchronous flush.
module xor_frame_buffer #(
   parameter int unsigned      WIDTH   = 8,
   parameter int unsigned      DEPTH   = 4,
   parameter logic [WIDTH-1:0] MASK    = WIDTH'(8'hAA),
   parameter int unsigned      TIMEOUT = 16
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       flush_i,
   xor_frame_buffer_if.slave          bus,
   output logic [1:0]                 state_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic [7:0]                 frames_o,
   output logic                       error_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACTIVE = 2'b01,
      S_DONE   = 2'b10,
      S_ERROR  = 2'b11
   } state_t;

   state_t           state;
   logic [IW-1:0]    wr_idx;
   logic [IW-1:0]    rd_idx;
   logic [CW-1:0]    count;
   logic [7:0]       frames;
   logic [TW-1:0]    tmo_cnt;
   logic [WIDTH-1:0] mem [DEPTH];

   logic in_accept;
   logic out_xfer;

   // Handshake outputs are pure decodes of the registered state.
   assign bus.in_ready  = (state == S_IDLE) || (state == S_ACTIVE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.out_data  = bus.out_valid ? mem[rd_idx] : '0;

   assign in_accept = bus.in_valid & bus.in_ready;
   assign out_xfer  = bus.out_valid & bus.out_ready;

   assign state_o  = state;
   assign count_o  = count;
   assign frames_o = frames;
   assign error_o  = (state == S_ERROR);

   // NOTE: the sample array carries no reset; its contents are never read
   // before being written within the same frame, so a reset would only cost flops.
   always_ff @(posedge clk_i) begin
      if (in_accept && !flush_i)
         mem[wr_idx] <= bus.in_data ^ MASK;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state   <= S_IDLE;
         wr_idx  <= '0;
         rd_idx  <= '0;
         count   <= '0;
         frames  <= '0;
         tmo_cnt <= '0;
      end else if (flush_i) begin
         state   <= S_IDLE;
         wr_idx  <= '0;
         rd_idx  <= '0;
         count   <= '0;
         tmo_cnt <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_accept) begin
                  state   <= S_ACTIVE;
                  wr_idx  <= IW'(1);
                  count   <= CW'(1);
                  tmo_cnt <= '0;
               end
            end
            S_ACTIVE: begin
               if (in_accept) begin
                  tmo_cnt <= '0;
                  count   <= count + 1'b1;
                  if (count == CW'(DEPTH - 1)) begin
                     state  <= S_DONE;
                     wr_idx <= '0;
                  end else begin
                     wr_idx <= wr_idx + 1'b1;
                  end
               end else begin
                  // The idle cycle that brings the counter to TIMEOUT-1 trips the error.
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (tmo_cnt == TW'(TIMEOUT - 2))
                     state <= S_ERROR;
               end
            end
            S_DONE: begin
               if (out_xfer) begin
                  count <= count - 1'b1;
                  if (rd_idx == IW'(DEPTH - 1)) begin
                     state  <= S_IDLE;
                     rd_idx <= '0;
                     wr_idx <= '0;
                     frames <= frames + 8'd1;
                  end else begin
                     rd_idx <= rd_idx + 1'b1;
                  end
               end
            end
            S_ERROR: begin
               state <= S_ERROR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xor_frame_buffer.sv
// Directed + randomized bench for xor_frame_buffer against a queue-based frame model.
module tb_xor_frame_buffer;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       flush;
   logic [1:0] state_o;
   logic [2:0] count_o;
   logic [7:0] frames_o;
   logic       error_o;

   xor_frame_buffer_if #(.WIDTH(WIDTH)) bus ();

   xor_frame_buffer #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .MASK(8'hAA), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .flush_i   (flush),
      .bus       (bus),
      .state_o   (state_o),
      .count_o   (count_o),
      .frames_o  (frames_o),
      .error_o   (error_o)
   );

   always #5 clk = ~clk;

   int    n_tests = 0;
   int    n_fail  = 0;
   string phase   = "reset";

   // Reference model: the frame is a queue of masked samples.
   logic [7:0] m_q[$];
   bit         m_draining;
   bit         m_err;
   int         m_idle;
   int         m_frames;
   int         m_total;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_draining = 0;
      m_err      = 0;
      m_idle     = 0;
      m_frames   = 0;
   endtask

   task automatic model_edge(input logic v, input logic [7:0] d, input logic r, input logic f);
      logic [7:0] tmp;
      if (f) begin
         m_q.delete();
         m_draining = 0;
         m_err      = 0;
         m_idle     = 0;
      end else if (m_err) begin
         m_err = 1;
      end else if (m_draining) begin
         if (r) begin
            tmp = m_q.pop_front();
            if (m_q.size() == 0) begin
               m_draining = 0;
               m_frames   = (m_frames + 1) % 256;
               m_total++;
            end
         end
      end else if (v) begin
         m_q.push_back(d ^ 8'hAA);
         m_idle = 0;
         if (m_q.size() == DEPTH) m_draining = 1;
      end else if (m_q.size() > 0) begin
         m_idle++;
         if (m_idle == TIMEOUT - 1) m_err = 1;
      end
   endtask

   task automatic compare_all();
      int exp_state;
      exp_state = m_err ? 3 : m_draining ? 2 : (m_q.size() > 0) ? 1 : 0;
      check("state",     state_o,       exp_state);
      check("count",     count_o,       m_q.size());
      check("frames",    frames_o,      m_frames);
      check("in_ready",  bus.in_ready,  !m_draining && !m_err);
      check("out_valid", bus.out_valid, m_draining);
      check("out_data",  bus.out_data,  m_draining ? m_q[0] : 8'h00);
      check("error",     error_o,       m_err);
   endtask

   // One clock: drive inputs, advance the model, compare after the edge.
   task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic f);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      flush         = f;
      model_edge(v, d, r, f);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      flush        = 1'b0;
      compare_all();
   endtask

   initial begin
      reset_n       = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      m_total       = 0;
      model_reset();
      #12;
      check("rst_state",    state_o,       2'b00);
      check("rst_count",    count_o,       3'd0);
      check("rst_frames",   frames_o,      8'h00);
      check("rst_in_ready", bus.in_ready,  1'b1);
      check("rst_out_val",  bus.out_valid, 1'b0);
      check("rst_out_data", bus.out_data,  8'h00);
      check("rst_error",    error_o,       1'b0);
      reset_n = 1'b1;

      phase = "basic";
      cycle(1, 8'h00, 1, 0);
      check("first_active", state_o, 2'b01);
      for (int i = 1; i < 4; i++) cycle(1, 8'(i), 1, 0);
      check("full_done", state_o, 2'b10);
      check("d0", bus.out_data, 8'hAA);
      cycle(0, 0, 1, 0);
      check("d1", bus.out_data, 8'hAB);
      cycle(0, 0, 1, 0);
      check("d2", bus.out_data, 8'hA8);
      cycle(0, 0, 1, 0);
      check("d3", bus.out_data, 8'hA9);
      cycle(0, 0, 1, 0);
      check("drained_idle", state_o, 2'b00);
      check("frames_one", frames_o, 8'h01);

      phase = "backpressure";
      cycle(1, 8'h00, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 8'($urandom), 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
      check("held_data",  bus.out_data, 8'hAA);
      check("held_count", count_o, 3'd4);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
      check("bp_count_zero", count_o, 3'd0);

      phase = "timeout";
      cycle(1, 8'($urandom), 0, 0);
      for (int i = 0; i < 14; i++) cycle(0, 0, 0, 0);
      check("pre_timeout", state_o, 2'b01);
      cycle(0, 0, 0, 0);
      check("timeout_state", state_o, 2'b11);
      check("timeout_err",   error_o, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1, 8'($urandom), 1, 0);
      cycle(0, 0, 0, 1);
      check("flush_state", state_o, 2'b00);
      check("flush_err",   error_o, 1'b0);

      phase = "edge_accept";
      cycle(1, 8'($urandom), 0, 0);
      for (int i = 0; i < 14; i++) cycle(0, 0, 0, 0);
      cycle(1, 8'($urandom), 0, 0);
      check("edge_state", state_o, 2'b01);
      check("edge_count", count_o, 3'd2);
      cycle(0, 0, 0, 1);

      phase = "flush_accept";
      for (int i = 0; i < 3; i++) cycle(1, 8'($urandom), 0, 0);
      cycle(1, 8'h55, 0, 1);
      check("fa_state",  state_o,  2'b00);
      check("fa_count",  count_o,  3'd0);
      check("fa_frames", frames_o, 8'h02);
      for (int i = 0; i < 4; i++) cycle(1, 8'($urandom), 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

      phase = "wrap";
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      reset_n = 1'b1;
      m_total = 0;
      for (int i = 0; i < 20000 && m_total < 257; i++) begin
         if (m_err) cycle(0, 0, 0, 1);
         else cycle($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)), 0);
      end
      check("frames_wrap", frames_o, 8'h01);

      phase = "async_reset";
      cycle(1, 8'($urandom), 0, 0);
      cycle(1, 8'($urandom), 0, 0);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      check("ar_state", state_o, 2'b00);
      #1;
      reset_n = 1'b1;
      cycle(1, 8'h3C, 0, 0);
      check("post_reset_count", count_o, 3'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
